// File: rtl/stark_fpu0_issue_arb_if.sv
// Handshake bundle between the FPU0 reservation stations, the FPU0 datapath,
// writeback, and the FPU0 issue arbiter.
interface stark_fpu0_issue_arb_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 8
);
  localparam int SELW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      gnt;
  logic                 fpu_start;
  logic [SELW-1:0]      fpu_sel;
  logic                 fpu_done;
  logic                 flush;
  logic                 wb_valid;
  logic [TAGW-1:0]      wb_tag;
  logic                 wb_ack;
  logic                 busy;
  logic                 err_tmo;

  // master: stations / datapath / writeback side that drives requests and acks
  modport master (
    output req, req_tag, fpu_done, flush, wb_ack,
    input  gnt, fpu_start, fpu_sel, wb_valid, wb_tag, busy, err_tmo
  );

  // slave: the arbiter itself
  modport slave (
    input  req, req_tag, fpu_done, flush, wb_ack,
    output gnt, fpu_start, fpu_sel, wb_valid, wb_tag, busy, err_tmo
  );
endinterface

// File: rtl/stark_fpu0_issue_arb.sv
// Round-robin issue arbiter for the shared, non-pipelined FPU0: one op in
// flight, result tag handed to writeback, flush drain and a sticky watchdog.
//
//   state | meaning
//   IDLE  | no op in flight; arbitrate req from rr_ptr upward
//   BUSY  | op issued to FPU0, waiting for fpu_done
//   WB    | result tag presented, waiting for wb_ack
//   DRAIN | op flushed, waiting for FPU0 to finish it silently
module stark_fpu0_issue_arb #(
  parameter int NREQ = 4,
  parameter int TAGW = 8,
  parameter int TMO  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stark_fpu0_issue_arb_if.slave  bus
);
  localparam int SELW = $clog2(NREQ);
  localparam int CNTW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            start_q, start_d;
  logic            wb_valid_q, wb_valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [SELW-1:0] win_idx;
  logic [SELW:0]   scan_sum;
  logic [SELW-1:0] sel_next;
  logic            tmo_hit;

  // rr_ptr < NREQ and k < NREQ, so one conditional subtract is a full wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (SELW+1)'(k);
      if (scan_sum >= (SELW+1)'(NREQ)) scan_sum = scan_sum - (SELW+1)'(NREQ);
      if (!win_found && bus.req[scan_sum[SELW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[SELW-1:0];
      end
    end
  end

  assign sel_next = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);
  assign tmo_hit  = (cnt_q == CNTW'(TMO - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    gnt_d      = '0;
    start_d    = 1'b0;
    wb_valid_d = wb_valid_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (!bus.flush && win_found) begin
          state_d        = BUSY;
          sel_d          = win_idx;
          tag_d          = bus.req_tag[win_idx*TAGW +: TAGW];
          gnt_d[win_idx] = 1'b1;
          start_d        = 1'b1;
          cnt_d          = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNTW'(1);
        // a flush coinciding with done retires the op directly, nothing left to drain
        if (bus.flush && bus.fpu_done) begin
          state_d  = IDLE;
          rr_ptr_d = sel_next;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end else if (bus.fpu_done) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          rr_ptr_d = sel_next;
        end
      end
      WB: begin
        if (bus.flush || bus.wb_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
          rr_ptr_d   = sel_next;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNTW'(1);
        if (bus.fpu_done) begin
          state_d  = IDLE;
          rr_ptr_d = sel_next;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          rr_ptr_d = sel_next;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      gnt_q      <= '0;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      gnt_q      <= gnt_d;
      start_q    <= start_d;
      wb_valid_q <= wb_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.fpu_start = start_q;
  assign bus.fpu_sel   = sel_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_tag    = tag_q;
  assign bus.busy      = busy_q;
  assign bus.err_tmo   = err_q;
endmodule

// File: tb/tb_stark_fpu0_issue_arb.sv
// Bench for stark_fpu0_issue_arb: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_stark_fpu0_issue_arb;
  localparam int NREQ = 4;
  localparam int TAGW = 8;
  localparam int TMO  = 16;

  localparam int P_IDLE  = 0;
  localparam int P_EXEC  = 1;
  localparam int P_WB    = 2;
  localparam int P_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  stark_fpu0_issue_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  stark_fpu0_issue_arb #(.NREQ(NREQ), .TAGW(TAGW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model: phase of the single outstanding op plus timestamps
  int       m_phase, m_ptr, m_sel, m_start_edge, edge_n;
  bit [7:0] m_tag;
  bit       m_err, e_start, e_wbv;
  bit [3:0] e_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_ptr = 0; m_sel = 0; m_start_edge = 0;
    m_tag = 0; m_err = 0; e_start = 0; e_wbv = 0; e_gnt = 0;
  endtask

  task automatic retire();
    m_phase = P_IDLE;
    m_ptr   = (m_sel + 1) % NREQ;
    e_wbv   = 0;
  endtask

  // predicts the state after the upcoming rising edge from the inputs now applied
  task automatic model_step();
    int  nxt;
    bit  found;
    bit  expired;
    nxt     = edge_n + 1;
    expired = ((nxt - m_start_edge) == TMO);
    e_gnt   = 0;
    e_start = 0;
    found   = 0;
    case (m_phase)
      P_IDLE: if (!bus.flush && bus.req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (!found && ((bus.req >> idx) & 4'b0001) != 0) begin
            found = 1;
            m_sel = idx;
          end
        end
        m_tag        = 8'(bus.req_tag >> (m_sel * TAGW));
        e_gnt        = 4'b0001 << m_sel;
        e_start      = 1;
        m_start_edge = nxt;
        m_phase      = P_EXEC;
      end
      P_EXEC: begin
        if (bus.flush && bus.fpu_done) retire();
        else if (bus.flush) m_phase = P_DRAIN;
        else if (bus.fpu_done) begin m_phase = P_WB; e_wbv = 1; end
        else if (expired) begin m_err = 1; retire(); end
      end
      P_WB: if (bus.flush || bus.wb_ack) retire();
      default: begin
        if (bus.fpu_done) retire();
        else if (expired) begin m_err = 1; retire(); end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("fpu_start", 32'(bus.fpu_start), 32'(e_start));
    if (e_start) chk("fpu_sel", 32'(bus.fpu_sel), 32'(m_sel));
    chk("wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
    if (e_wbv) chk("wb_tag", 32'(bus.wb_tag), 32'(m_tag));
    chk("busy", 32'(bus.busy), 32'(m_phase != P_IDLE));
    chk("err_tmo", 32'(bus.err_tmo), 32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    edge_n++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // called just after a rising edge; checks outputs clear while clock is mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
    chk("rst_wb_tag", 32'(bus.wb_tag), 32'(m_tag));
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    bus.req = 0; bus.req_tag = 0; bus.fpu_done = 0; bus.flush = 0; bus.wb_ack = 0;
    edge_n = 0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single request, done 6 cycles after start, ack same cycle as wb_valid
    bus.req = 4'b0100; bus.req_tag = 32'h0035_0000;
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'h4);
    chk("t1_sel", 32'(bus.fpu_sel), 32'd2);
    bus.req = 0;
    ticks(5);
    bus.fpu_done = 1; tick(); bus.fpu_done = 0;
    chk("t1_wb_tag", 32'(bus.wb_tag), 32'h35);
    bus.wb_ack = 1; tick(); bus.wb_ack = 0;
    chk("t1_busy_after", 32'(bus.busy), 32'd0);

    // 2: all requesting, immediate done/ack, fresh pointer
    @(posedge clk); #1; edge_n++;
    do_reset();
    bus.req = 4'b1111; bus.req_tag = 32'hD3C2_B1A0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_start", 32'(bus.fpu_start), 32'd1);
      chk("t2_order", 32'(bus.fpu_sel), 32'(order[i]));
      bus.fpu_done = 1; tick(); bus.fpu_done = 0;
      bus.wb_ack = 1; tick(); bus.wb_ack = 0;
      chk("t2_gap", 32'(bus.gnt), 32'd0);
    end
    bus.req = 0;
    tick();

    // 3: flush mid-op, done 5 cycles later, other station waits through drain
    bus.req = 4'b0001; bus.req_tag = 32'h4433_2211;
    tick();
    bus.req = 0;
    ticks(2);
    bus.flush = 1; tick(); bus.flush = 0;
    bus.req = 4'b0010;
    ticks(4);
    chk("t3_drain_busy", 32'(bus.busy), 32'd1);
    bus.fpu_done = 1; tick(); bus.fpu_done = 0;
    chk("t3_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("t3_next_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 0;
    bus.fpu_done = 1; tick(); bus.fpu_done = 0;
    bus.wb_ack = 1; tick(); bus.wb_ack = 0;

    // 4: flush and done together
    bus.req = 4'b0100;
    tick();
    bus.req = 0;
    ticks(2);
    bus.flush = 1; bus.fpu_done = 1; tick(); bus.flush = 0; bus.fpu_done = 0;
    chk("t4_idle", 32'(bus.busy), 32'd0);
    tick();

    // 5: watchdog, then a normal grant
    bus.req = 4'b1000;
    tick();
    bus.req = 0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("t5_err_early", 32'(bus.err_tmo), 32'd0);
    end
    tick();
    chk("t5_err_set", 32'(bus.err_tmo), 32'd1);
    bus.req = 4'b0001;
    tick();
    chk("t5_regrant", 32'(bus.gnt), 32'h1);
    bus.req = 0;
    bus.fpu_done = 1; tick(); bus.fpu_done = 0;
    bus.wb_ack = 1; tick(); bus.wb_ack = 0;

    // 6: wb_ack held off, then reset while in WB
    bus.req = 4'b0010; bus.req_tag = 32'h0000_9A00;
    tick();
    bus.req = 0; bus.req_tag = 0;
    ticks(2);
    bus.fpu_done = 1; tick(); bus.fpu_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_tag_stable", 32'(bus.wb_tag), 32'h9A);
    end
    do_reset();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.req_tag  = $urandom;
      bus.fpu_done = ($urandom_range(0, 4) == 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.wb_ack   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end
endmodule
